// File: rtl/fifo_writer_pkg.sv
// Shared defaults and FSM encoding for the FIFO write-side front end.
package fifo_writer_pkg;

   localparam int DAT_WIDTH_DEF = 32;
   localparam int CNT_W_DEF     = 16;

   // Skid buffer depth expressed as an occupancy value.
   localparam logic [1:0] OCC_EMPTY = 2'd0;
   localparam logic [1:0] OCC_ONE   = 2'd1;
   localparam logic [1:0] OCC_FULL  = 2'd2;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      STALL  = 2'd2
   } state_e;

endpackage

// File: rtl/fifo_writer_skid.sv
// Two-entry skid buffer of {data, last}; entry 0 is always the head.
module fifo_writer_skid
   import fifo_writer_pkg::*;
#(
   parameter int DAT_WIDTH = DAT_WIDTH_DEF
) (
   input  logic                 Wrclk,
   input  logic                 Rst,
   input  logic                 push,
   input  logic [DAT_WIDTH-1:0] push_data,
   input  logic                 push_last,
   input  logic                 pop,
   output logic [1:0]           occ,
   output logic [DAT_WIDTH-1:0] head_data,
   output logic                 head_last
);

   logic [1:0]           occ_q,   occ_d;
   logic [DAT_WIDTH-1:0] data0_q, data0_d, data1_q, data1_d;
   logic                 last0_q, last0_d, last1_q, last1_d;

   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
      occ_d   = occ_q;
      data0_d = data0_q;
      data1_d = data1_q;
      last0_d = last0_q;
      last1_d = last1_q;
      case ({push, pop})
         2'b10: begin
            if (occ_q == OCC_EMPTY) begin
               data0_d = push_data;
               last0_d = push_last;
            end else begin
               data1_d = push_data;
               last1_d = push_last;
            end
            occ_d = occ_q + 2'd1;
         end
         2'b01: begin
            data0_d = data1_q;
            last0_d = last1_q;
            occ_d   = occ_q - 2'd1;
         end
         2'b11: begin
            // Simultaneous push and pop: occupancy holds, order preserved by shifting.
            if (occ_q == OCC_ONE) begin
               data0_d = push_data;
               last0_d = push_last;
            end else begin
               data0_d = data1_q;
               last0_d = last1_q;
               data1_d = push_data;
               last1_d = push_last;
            end
         end
         default: ;
      endcase
   end

   // NOTE: the storage is reset too, because Datain must read zero while Rst is high.
   always_ff @(posedge Wrclk or posedge Rst) begin
      if (Rst) begin
         occ_q   <= OCC_EMPTY;
         data0_q <= '0;
         data1_q <= '0;
         last0_q <= 1'b0;
         last1_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         occ_q   <= occ_d;
         data0_q <= data0_d;
         data1_q <= data1_d;
         last0_q <= last0_d;
         last1_q <= last1_d;
      end
   end

   assign occ       = occ_q;
   assign head_data = data0_q;
   assign head_last = last0_q;

endmodule

// File: rtl/fifo_writer.sv
// FIFO write-side front end: skid buffer, IDLE/ACTIVE/STALL FSM, word/packet counters.
// Optional stall-cycle counter enabled by defining FIFO_WRITER_STALL_CNT_EN.
module fifo_writer
   import fifo_writer_pkg::*;
#(
   parameter int DAT_WIDTH = DAT_WIDTH_DEF,
   parameter int CNT_W     = CNT_W_DEF
) (
   input  logic                 Wrclk,
   input  logic                 Rst,
   input  logic [DAT_WIDTH-1:0] In_data,
   input  logic                 In_valid,
   input  logic                 In_last,
   output logic                 In_ready,
   input  logic                 Full,
   output logic                 Wren,
   output logic [DAT_WIDTH-1:0] Datain,
   output logic                 Busy,
   output logic                 Pkt_done,
   output logic [CNT_W-1:0]     Word_cnt,
   output logic [CNT_W-1:0]     Pkt_cnt
`ifdef FIFO_WRITER_STALL_CNT_EN
   ,
   output logic [CNT_W-1:0]     Stall_cnt
`endif
);

   logic [1:0]           occ, occ_nxt;
   logic [DAT_WIDTH-1:0] head_data;
   logic                 head_last;
   logic                 push, pop;

   state_e               state_q, state_d;
   logic [CNT_W-1:0]     word_cnt_q, word_cnt_d;
   logic [CNT_W-1:0]     pkt_cnt_q,  pkt_cnt_d;
   logic                 pkt_done_q, pkt_done_d;

   fifo_writer_skid #(.DAT_WIDTH(DAT_WIDTH)) u_skid (
      .Wrclk    (Wrclk),
      .Rst      (Rst),
      .push     (push),
      .push_data(In_data),
      .push_last(In_last),
      .pop      (pop),
      .occ      (occ),
      .head_data(head_data),
      .head_last(head_last)
   );

   // Handshake is purely combinational from registered occupancy and the live Full flag.
   assign In_ready = (occ != OCC_FULL);
   assign push     = In_valid && In_ready;
   assign Wren     = (occ != OCC_EMPTY) && !Full;
   assign pop      = Wren;
   assign Datain   = head_data;

   always_comb begin
      occ_nxt    = occ;
      if (push && !pop) begin
         occ_nxt = occ + 2'd1;
      end else if (pop && !push) begin
         occ_nxt = occ - 2'd1;
      end

      state_d    = ACTIVE;
      if (occ_nxt == OCC_EMPTY) begin
         state_d = IDLE;
      end else if (Full) begin
         state_d = STALL;
      end

      word_cnt_d = word_cnt_q + CNT_W'(pop);
      pkt_done_d = pop && head_last;
      pkt_cnt_d  = pkt_cnt_q + CNT_W'(pkt_done_d);
   end

   always_ff @(posedge Wrclk or posedge Rst) begin
      if (Rst) begin
         state_q    <= IDLE;
         word_cnt_q <= '0;
         pkt_cnt_q  <= '0;
         pkt_done_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         word_cnt_q <= word_cnt_d;
         pkt_cnt_q  <= pkt_cnt_d;
         pkt_done_q <= pkt_done_d;
      end
   end

   assign Busy     = (state_q != IDLE);
   assign Pkt_done = pkt_done_q;
   assign Word_cnt = word_cnt_q;
   assign Pkt_cnt  = pkt_cnt_q;

`ifdef FIFO_WRITER_STALL_CNT_EN
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   // Saturating count of cycles spent in STALL.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if ((state_q == STALL) && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge Wrclk or posedge Rst) begin
      if (Rst) begin
         stall_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign Stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_writer.sv
// Self-checking bench for fifo_writer: queue-based reference model plus directed scenarios.
module tb_fifo_writer;

   localparam int DW = 32;
   localparam int CW = 16;

   typedef struct {
      logic [DW-1:0] data;
      logic          last;
   } word_t;

   logic          Wrclk = 1'b0;
   logic          Rst;
   logic [DW-1:0] In_data;
   logic          In_valid;
   logic          In_last;
   logic          In_ready;
   logic          Full;
   logic          Wren;
   logic [DW-1:0] Datain;
   logic          Busy;
   logic          Pkt_done;
   logic [CW-1:0] Word_cnt;
   logic [CW-1:0] Pkt_cnt;
`ifdef FIFO_WRITER_STALL_CNT_EN
   logic [CW-1:0] Stall_cnt;
`endif

   fifo_writer #(.DAT_WIDTH(DW), .CNT_W(CW)) dut (
      .Wrclk   (Wrclk),
      .Rst     (Rst),
      .In_data (In_data),
      .In_valid(In_valid),
      .In_last (In_last),
      .In_ready(In_ready),
      .Full    (Full),
      .Wren    (Wren),
      .Datain  (Datain),
      .Busy    (Busy),
      .Pkt_done(Pkt_done),
      .Word_cnt(Word_cnt),
      .Pkt_cnt (Pkt_cnt)
`ifdef FIFO_WRITER_STALL_CNT_EN
      ,
      .Stall_cnt(Stall_cnt)
`endif
   );

   always #5 Wrclk = ~Wrclk;

   // Upstream source (words waiting to be offered) and the model's buffer contents.
   word_t         src[$];
   word_t         mq[$];
   logic [DW-1:0] obs_log[$];
   int            pkt_done_cycles;

   logic [CW-1:0] m_word_cnt;
   logic [CW-1:0] m_pkt_cnt;
   logic          m_pkt_done;
   logic          m_in_stall;
   logic [CW-1:0] m_stall_cnt;

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      src.delete();
      m_word_cnt  = '0;
      m_pkt_cnt   = '0;
      m_pkt_done  = 1'b0;
      m_in_stall  = 1'b0;
      m_stall_cnt = '0;
   endtask

   task automatic offer(input logic [DW-1:0] d, input logic l);
      word_t w;
      w.data = d;
      w.last = l;
      src.push_back(w);
   endtask

   // One clock cycle; entered 1ns after a rising edge, leaves 1ns after the next one.
   task automatic cycle(input logic full_i);
      logic  exp_ready, exp_wren;
      word_t w;
      Full = full_i;
      if (src.size() != 0) begin
         In_valid = 1'b1;
         In_data  = src[0].data;
         In_last  = src[0].last;
      end else begin
         In_valid = 1'b0;
         In_data  = $urandom;
         In_last  = 1'($urandom_range(0, 1));
      end
      #1;
      exp_ready = (mq.size() < 2);
      exp_wren  = (mq.size() != 0) && !full_i;
      check("in_ready", In_ready, exp_ready);
      check("wren", Wren, exp_wren);
      check("busy", Busy, mq.size() != 0);
      if (exp_wren) check("datain", Datain, mq[0].data);
      check("word_cnt", Word_cnt, m_word_cnt);
      check("pkt_cnt", Pkt_cnt, m_pkt_cnt);
      check("pkt_done", Pkt_done, m_pkt_done);
`ifdef FIFO_WRITER_STALL_CNT_EN
      check("stall_cnt", Stall_cnt, m_stall_cnt);
`endif
      if (Wren) obs_log.push_back(Datain);
      if (Pkt_done) pkt_done_cycles++;

      if (m_in_stall && (m_stall_cnt != '1)) m_stall_cnt++;
      m_pkt_done = 1'b0;
      if (exp_wren) begin
         w = mq.pop_front();
         m_word_cnt++;
         if (w.last) begin
            m_pkt_cnt++;
            m_pkt_done = 1'b1;
         end
      end
      if (In_valid && exp_ready) begin
         w.data = In_data;
         w.last = In_last;
         mq.push_back(w);
         void'(src.pop_front());
      end
      m_in_stall = (mq.size() != 0) && full_i;

      @(posedge Wrclk);
      #1;
   endtask

   initial begin
      Rst      = 1'b1;
      Full     = 1'b0;
      In_valid = 1'b0;
      In_data  = '0;
      In_last  = 1'b0;
      model_reset();
      pkt_done_cycles = 0;

      // Reset state.
      #2;
      check("rst_wren", Wren, 1'b0);
      check("rst_busy", Busy, 1'b0);
      check("rst_ready", In_ready, 1'b1);
      check("rst_datain", Datain, 32'h0);
      check("rst_word_cnt", Word_cnt, 16'h0);
      check("rst_pkt_cnt", Pkt_cnt, 16'h0);
      check("rst_pkt_done", Pkt_done, 1'b0);
      @(posedge Wrclk);
      #1;
      Rst = 1'b0;

      // Straight stream of 8 words, Full low.
      for (int i = 1; i <= 8; i++) offer(DW'(i), 1'b0);
      repeat (12) cycle(1'b0);
      check("stream_word_cnt", Word_cnt, 16'd8);
      check("stream_writes", obs_log.size(), 8);
      for (int i = 0; i < 8; i++)
         if (i < obs_log.size()) check("stream_order", obs_log[i], 32'(i + 1));

      // Full asserted before the first accept: buffer fills to 2, then drains in order.
      obs_log.delete();
      for (int i = 1; i <= 3; i++) offer(DW'(i), 1'b0);
      repeat (4) cycle(1'b1);
      check("full_ready_low", In_ready, 1'b0);
      check("full_no_wren", Wren, 1'b0);
      check("full_busy", Busy, 1'b1);
      repeat (6) cycle(1'b0);
      check("full_writes", obs_log.size(), 3);
      for (int i = 0; i < 3; i++)
         if (i < obs_log.size()) check("full_order", obs_log[i], 32'(i + 1));

      // Two packets: 4 words then 1 word.
      pkt_done_cycles = 0;
      for (int i = 0; i < 4; i++) offer(32'h100 + DW'(i), i == 3);
      offer(32'h200, 1'b1);
      repeat (10) cycle(1'b0);
      check("pkt_done_cycles", pkt_done_cycles, 2);
      check("pkt_cnt_2", Pkt_cnt, 16'd2);
      check("pkt_word_cnt", Word_cnt, 16'd16);

      // Randomized traffic with random backpressure.
      for (int i = 0; i < 400; i++) begin
         if ((src.size() < 2) && ($urandom_range(0, 2) != 0))
            offer($urandom, 1'($urandom_range(0, 3) == 0));
         cycle($urandom_range(0, 3) == 0);
      end
      repeat (8) cycle(1'b0);

      // Reset while the buffer is full and stalled; Full drops with Rst so a live Wren would show.
      for (int i = 0; i < 3; i++) offer(32'hDEAD0000 + DW'(i), 1'b0);
      repeat (3) cycle(1'b1);
      check("pre_rst_occ2", In_ready, 1'b0);
      Rst      = 1'b1;
      Full     = 1'b0;
      In_valid = 1'b0;
      #1;
      check("mid_rst_wren", Wren, 1'b0);
      check("mid_rst_busy", Busy, 1'b0);
      check("mid_rst_ready", In_ready, 1'b1);
      check("mid_rst_datain", Datain, 32'h0);
      check("mid_rst_word_cnt", Word_cnt, 16'h0);
      check("mid_rst_pkt_cnt", Pkt_cnt, 16'h0);
      check("mid_rst_pkt_done", Pkt_done, 1'b0);
      model_reset();
      @(posedge Wrclk);
      #3;
      Rst = 1'b0;
      @(posedge Wrclk);
      #1;

      // First word after reset must be the new one.
      obs_log.delete();
      offer(32'hA5A5A5A5, 1'b0);
      repeat (4) cycle(1'b0);
      check("post_rst_first", (obs_log.size() != 0) ? obs_log[0] : 32'hx, 32'hA5A5A5A5);
      check("post_rst_writes", obs_log.size(), 1);

      // Full high for 10 cycles with a word held.
      offer(32'h5555AAAA, 1'b0);
      repeat (11) cycle(1'b1);
`ifdef FIFO_WRITER_STALL_CNT_EN
      check("stall_cnt_10", Stall_cnt, 16'd10);
`endif
      repeat (3) cycle(1'b0);

      // Drive Word_cnt up to 0xFFFF, then wrap it with 2 more writes.
      for (int i = 0; i < 65533; i++) offer(DW'(i), 1'b0);
      for (int i = 0; i < 65540 && ((src.size() != 0) || (mq.size() != 0)); i++) cycle(1'b0);
      check("wrap_pre", Word_cnt, 16'hFFFF);
      offer(32'h1, 1'b0);
      offer(32'h2, 1'b0);
      repeat (4) cycle(1'b0);
      check("wrap_post", Word_cnt, 16'h0001);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
